msg_validator: RTL

MSG_VALIDATOR -- requirements
Module: msg_validator

---
 rtl/msg_validator.sv | 100 ++++++++++
 1 files changed

// File: rtl/msg_validator.sv
// Scans MESSAGE_LEN bytes of a decrypted-message RAM and reports whether every
// byte is a space or lowercase letter, aborting at the first offending index.
module msg_validator #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MESSAGE_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] msg_addr,
    input  logic [DATA_WIDTH-1:0] msg_q,
    output logic                  finish,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] bad_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(MESSAGE_LEN - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] k_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  finish_q;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] bad_q;
    logic                  byte_ok;

    always_comb begin
        byte_ok = (msg_q == DATA_WIDTH'(8'h20)) ||
                  ((msg_q >= DATA_WIDTH'(8'h61)) && (msg_q <= DATA_WIDTH'(8'h7A)));
    end

    // k is compared against the last index before incrementing, so a message
    // filling the whole address space never wraps the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            addr_q   <= '0;
            finish_q <= 1'b0;
            valid_q  <= 1'b0;
            bad_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        k_q     <= '0;
                        addr_q  <= '0;
                        valid_q <= 1'b0;
                        bad_q   <= '0;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR:  state_q <= S_WAIT;
                S_WAIT:  state_q <= S_CHECK;
                S_CHECK: begin
                    if (!byte_ok) begin
                        valid_q  <= 1'b0;
                        bad_q    <= k_q;
                        finish_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (k_q == LAST_K) begin
                        valid_q  <= 1'b1;
                        bad_q    <= '0;
                        finish_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        k_q     <= k_q + ADDR_WIDTH'(1);
                        addr_q  <= k_q + ADDR_WIDTH'(1);
                        state_q <= S_ADDR;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        finish_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    finish_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign msg_addr = addr_q;
    assign finish   = finish_q;
    assign valid    = valid_q;
    assign bad_addr = bad_q;

endmodule
